pc_module: RTL and testbench

PC_MODULE -- requirements
Module: pc_module

---
 rtl/pc_module_pkg.sv | 11 +
 rtl/pc_align_check.sv | 17 +
 rtl/pc_module.sv | 80 ++++++++
 tb/tb_pc_module.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/pc_module_pkg.sv
// Shared constants and types for the program-counter block.
package pc_module_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] pc_t;

  localparam pc_t DefaultResetVector = 32'h0000_0000;
  localparam pc_t PcInc              = 32'd4;

endpackage

// File: rtl/pc_align_check.sv
// Accept/reject decision for an incoming PC_Next based on its two low bits.
// With PC_MODULE_ALIGN_CHECK_EN undefined every address is accepted.
module pc_align_check (
  input  logic [1:0] pc_lo,
  output logic       accept
);

`ifdef PC_MODULE_ALIGN_CHECK_EN
  // Only word-aligned targets may be loaded.
  assign accept = (pc_lo == 2'b00);
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^pc_lo;
  assign accept       = 1'b1;
`endif

endmodule

// File: rtl/pc_module.sv
// Program counter register with combinational PC + PC_INC and an optional
// alignment check (macro PC_MODULE_ALIGN_CHECK_EN). Rejected misaligned targets
// leave PC untouched, pulse PC_Misaligned for one cycle and land in Bad_Addr.
module pc_module
  import pc_module_pkg::*;
#(
  parameter pc_t RESET_VECTOR = DefaultResetVector,
  parameter pc_t PC_INC       = PcInc
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] PC_Next,
  output logic [31:0] PC,
  output logic [31:0] PC_Plus4,
  output logic        PC_Misaligned,
  output logic [31:0] Bad_Addr
);

  logic accept;
  pc_t  pc_q, pc_d;

  pc_align_check u_align_check (
    .pc_lo  (PC_Next[1:0]),
    .accept (accept)
  );

  // Next PC: load only on an enabled, accepted request; otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (en && accept) begin
      pc_d = PC_Next;
    end
  end

  // PC register, asynchronously forced to the reset vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC       = pc_q;
  assign PC_Plus4 = pc_q + PC_INC;

`ifdef PC_MODULE_ALIGN_CHECK_EN
  logic mis_q, mis_d;
  pc_t  bad_q, bad_d;

  // Rejection pulse is set only by the cycle's own rejected request.
  always_comb begin
    mis_d = 1'b0;
    bad_d = bad_q;
    if (en && !accept) begin
      mis_d = 1'b1;
      bad_d = PC_Next;
    end
  end

  // Fault-report registers, cleared asynchronously with the PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_q <= 1'b0;
      bad_q <= '0;
    end else begin
      mis_q <= mis_d;
      bad_q <= bad_d;
    end
  end

  assign PC_Misaligned = mis_q;
  assign Bad_Addr      = bad_q;
`else
  assign PC_Misaligned = 1'b0;
  assign Bad_Addr      = '0;
`endif

endmodule

// File: tb/tb_pc_module.sv
// Self-checking bench for pc_module: directed scenarios plus randomized
// enable/target/reset traffic checked against a behavioural model.
module tb_pc_module;

`ifdef PC_MODULE_ALIGN_CHECK_EN
  localparam bit AlignOn = 1'b1;
`else
  localparam bit AlignOn = 1'b0;
`endif

  localparam logic [31:0] ResetVec = 32'h0000_0000;
  localparam logic [31:0] Inc      = 32'd4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        pc_mis;
  logic [31:0] bad_addr;

  int unsigned n_checks;
  int unsigned n_errors;

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_bad;
  logic        m_mis;

  pc_module dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .PC_Next       (pc_next),
    .PC            (pc),
    .PC_Plus4      (pc_plus4),
    .PC_Misaligned (pc_mis),
    .Bad_Addr      (bad_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".pc"}, pc, m_pc);
    check_val({tag, ".plus4"}, pc_plus4, m_pc + Inc);
    check_val({tag, ".mis"}, {31'b0, pc_mis}, {31'b0, m_mis});
    check_val({tag, ".bad"}, bad_addr, m_bad);
  endtask

  function automatic void model_reset();
    m_pc  = ResetVec;
    m_bad = 32'h0;
    m_mis = 1'b0;
  endfunction

  // One rising edge with rst high.
  function automatic void model_edge(input logic e, input logic [31:0] nxt);
    m_mis = 1'b0;
    if (e) begin
      if (AlignOn && (nxt % 4 != 0)) begin
        m_mis = 1'b1;
        m_bad = nxt;
      end else begin
        m_pc = nxt;
      end
    end
  endfunction

  task automatic step(input string tag, input logic e, input logic [31:0] nxt);
    en      = e;
    pc_next = nxt;
    @(posedge clk);
    #1;
    model_edge(e, nxt);
    check_all(tag);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic mid_cycle_reset(input string tag);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] nxt;
    logic        e;
    n_checks = 0;
    n_errors = 0;
    model_reset();

    // Reset held for two cycles with a live PC_Next and en.
    rst     = 1'b0;
    en      = 1'b1;
    pc_next = 32'h1234_5678;
    #1;
    check_val("rst_async_pc", pc, 32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    check_all("rst_hold");
    #2;
    rst = 1'b1;
    step("release", 1'b1, 32'h1234_5678);
    check_val("release_pc", pc, 32'h1234_5678);
    check_val("release_plus4", pc_plus4, 32'h1234_567C);

    // Sequential fetch from 0.
    step("load0", 1'b1, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      step("seq", 1'b1, pc_plus4);
      check_val("seq_const", pc, 32'(4 * i));
    end

    // Stall.
    for (int i = 0; i < 3; i++) step("stall", 1'b0, 32'hDEAD_BEE0);
    check_val("stall_hold", pc, 32'h0000_0010);
    step("unstall", 1'b1, 32'hDEAD_BEE0);
    check_val("unstall_pc", pc, 32'hDEAD_BEE0);

    // Misaligned target, then confirm the pulse lasts one cycle.
    step("load100", 1'b1, 32'h100);
    step("misalign", 1'b1, 32'hFCB4_7047);
    check_val("misalign_pc", pc, AlignOn ? 32'h100 : 32'hFCB4_7047);
    check_val("misalign_flag", {31'b0, pc_mis}, {31'b0, AlignOn});
    check_val("misalign_bad", bad_addr, AlignOn ? 32'hFCB4_7047 : 32'h0);
    step("mis_stall", 1'b0, 32'h0000_0203);
    // Back-to-back misaligned requests.
    step("b2b_a", 1'b1, 32'h0000_0201);
    step("b2b_b", 1'b1, 32'h0000_0302);
    check_val("b2b_bad", bad_addr, AlignOn ? 32'h0000_0302 : 32'h0);
    // Reset during a misalign pulse.
    if (AlignOn) mid_cycle_reset("rst_mid_pulse");
    step("after_pulse_rst", 1'b1, 32'h0000_0400);

    // Wrap and mid-cycle reset.
    step("load_top", 1'b1, 32'hFFFF_FFFC);
    check_val("wrap_plus4", pc_plus4, 32'h0000_0000);
    mid_cycle_reset("rst_mid_cycle");
    check_val("rst_mid_pc", pc, ResetVec);
    step("post_rst", 1'b1, 32'h0000_0040);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      e   = ($urandom_range(0, 3) != 0);
      nxt = $urandom;
      if ($urandom_range(0, 1) == 0) nxt[1:0] = 2'b00;
      if ($urandom_range(0, 29) == 0) begin
        mid_cycle_reset("rand_rst");
      end else begin
        step("rand", e, nxt);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
